// File: rtl/bootrom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// bootrom_arbiter_pkg : shared types and defaults for the boot ROM arbiter
// Revision 1.0
// ============================================================================
package bootrom_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_REJECT = 3'd4
    } state_t;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_t;

    localparam int PROT_LIMIT_DEFAULT = 8;

    // A limit above the address space protects everything; zero protects nothing.
    function automatic logic is_protected(input int unsigned addr, input int unsigned limit);
        return addr < limit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bootrom_rr_pick.sv
`default_nettype none
// ============================================================================
// bootrom_rr_pick : 2-way round-robin picker, favours the port not granted last
// Revision 1.0
// ============================================================================
module bootrom_rr_pick
    import bootrom_arbiter_pkg::*;
(
    input  logic req_a_i,
    input  logic req_b_i,
    input  sel_t last_grant_i,
    output sel_t grant_o,
    output logic valid_o
);

    always_comb begin
        valid_o = req_a_i | req_b_i;
        if (req_a_i && req_b_i) begin
            grant_o = (last_grant_i == SEL_A) ? SEL_B : SEL_A;
        end else if (req_b_i) begin
            grant_o = SEL_B;
        end else begin
            grant_o = SEL_A;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bootrom_arbiter.sv
`default_nettype none
// ============================================================================
// bootrom_arbiter : shares the boot ROM / patch store between ports A and B
// Revision 1.0
// ============================================================================
module bootrom_arbiter
    import bootrom_arbiter_pkg::*;
#(
    parameter int PROT_LIMIT = PROT_LIMIT_DEFAULT,
    parameter int AW         = 4,
    parameter int DW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req_i,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_din_i,
    output logic          a_ack_o,
    output logic          a_err_o,
    output logic [DW-1:0] a_dout_o,
    input  logic          b_req_i,
    input  logic          b_we_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [DW-1:0] b_din_i,
    output logic          b_ack_o,
    output logic          b_err_o,
    output logic [DW-1:0] b_dout_o,
    output logic          rom_cs_o,
    output logic          rom_we_o,
    output logic [AW-1:0] rom_addr_o,
    output logic [DW-1:0] rom_din_o,
    input  logic [DW-1:0] rom_dout_i
);

    state_t        state_q;
    sel_t          sel_q;
    sel_t          last_grant_q;
    sel_t          w_grant;
    logic          w_valid;
    logic          w_we;
    logic          w_prot;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_din;

    logic          cmd_we_q;
    logic [AW-1:0] cmd_addr_q;
    logic [DW-1:0] cmd_din_q;

    logic          a_ack_q, a_err_q, b_ack_q, b_err_q;
    logic [DW-1:0] a_dout_q, b_dout_q;

    logic          rom_cs_d, rom_we_d;
    logic          rom_cs_q, rom_we_q;
    logic [AW-1:0] rom_addr_q;
    logic [DW-1:0] rom_din_q;

    bootrom_rr_pick u_pick (
        .req_a_i      (a_req_i),
        .req_b_i      (b_req_i),
        .last_grant_i (last_grant_q),
        .grant_o      (w_grant),
        .valid_o      (w_valid)
    );

    always_comb begin
        w_we   = (w_grant == SEL_B) ? b_we_i   : a_we_i;
        w_addr = (w_grant == SEL_B) ? b_addr_i : a_addr_i;
        w_din  = (w_grant == SEL_B) ? b_din_i  : a_din_i;
        w_prot = is_protected(32'(w_addr), unsigned'(PROT_LIMIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sel_q        <= SEL_A;
            last_grant_q <= SEL_B;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_din_q    <= '0;
            a_ack_q      <= 1'b0;
            a_err_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            b_err_q      <= 1'b0;
            a_dout_q     <= '0;
            b_dout_q     <= '0;
        end else begin
            a_ack_q <= 1'b0;
            a_err_q <= 1'b0;
            b_ack_q <= 1'b0;
            b_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_valid) begin
                        sel_q        <= w_grant;
                        last_grant_q <= w_grant;
                        cmd_we_q     <= w_we;
                        cmd_addr_q   <= w_addr;
                        cmd_din_q    <= w_din;
                        state_q      <= (w_we && w_prot) ? ST_REJECT : ST_SETUP;
                    end
                end
                ST_SETUP: state_q <= ST_ACCESS;
                ST_ACCESS: begin
                    if (!cmd_we_q) begin
                        if (sel_q == SEL_B) b_dout_q <= rom_dout_i;
                        else                a_dout_q <= rom_dout_i;
                    end
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (sel_q == SEL_B) b_ack_q <= 1'b1;
                    else                a_ack_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                ST_REJECT: begin
                    if (sel_q == SEL_B) begin
                        b_ack_q <= 1'b1;
                        b_err_q <= 1'b1;
                    end else begin
                        a_ack_q <= 1'b1;
                        a_err_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ROM controls move only while clk is low, so the gated write clock sees one clean edge.
    always_comb begin
        rom_cs_d = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
        rom_we_d = (state_q == ST_SETUP) && cmd_we_q;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            rom_cs_q   <= 1'b0;
            rom_we_q   <= 1'b0;
            rom_addr_q <= '0;
            rom_din_q  <= '0;
        end else begin
            rom_cs_q   <= rom_cs_d;
            rom_we_q   <= rom_we_d;
            rom_addr_q <= cmd_addr_q;
            rom_din_q  <= cmd_din_q;
        end
    end

    assign a_ack_o    = a_ack_q;
    assign a_err_o    = a_err_q;
    assign a_dout_o   = a_dout_q;
    assign b_ack_o    = b_ack_q;
    assign b_err_o    = b_err_q;
    assign b_dout_o   = b_dout_q;
    assign rom_cs_o   = rom_cs_q;
    assign rom_we_o   = rom_we_q;
    assign rom_addr_o = rom_addr_q;
    assign rom_din_o  = rom_din_q;

endmodule
`default_nettype wire
